// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned DEFAULT_ADDR_W         = 32;
    localparam int unsigned DEFAULT_DATA_W         = 32;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 15;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        FAULT
    } fetch_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10
    } fault_code_t;

    // Instructions are 32-bit words, so the two low PC bits must be zero.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts REQ cycles spent without an acknowledge; expired flags the last allowed one.
module fetch_timeout_counter
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned          CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch controller: reads the word at the current PC, holds it until the core
// accepts it, then pulses pc_advance. Misaligned PCs and timeouts raise a sticky fault.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_accept,
    output logic              pc_advance,
    output logic              fault,
    output logic [1:0]        fault_code,
    input  logic              fault_clear
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    fault_code_t       fault_code_q;
    fault_code_t       fault_code_d;

    logic              mem_req_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] instr_d;
    logic              instr_valid_d;
    logic              pc_advance_d;
    logic              fault_d;

    logic              start_fetch;
    logic              aligned;
    logic              waiting;
    logic              expired;

    assign aligned     = is_word_aligned(pc_in[1:0]);
    assign start_fetch = (state == IDLE) && fetch_en && aligned;
    assign waiting     = (state == REQ) && !mem_ack;
    assign fault_code  = fault_code_q;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_fetch),
        .enable  (waiting),
        .expired (expired)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            instr        <= '0;
            instr_valid  <= 1'b0;
            pc_advance   <= 1'b0;
            fault        <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state        <= state_next;
            mem_req      <= mem_req_d;
            mem_addr     <= mem_addr_d;
            instr        <= instr_d;
            instr_valid  <= instr_valid_d;
            pc_advance   <= pc_advance_d;
            fault        <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (fetch_en) state_next = aligned ? REQ : FAULT;
            REQ: begin
                if (mem_ack)      state_next = HOLD;
                else if (expired) state_next = FAULT;
            end
            HOLD:  if (instr_accept) state_next = IDLE;
            FAULT: if (fault_clear)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the output registers; pc_advance is a single-cycle pulse.
    always_comb begin
        mem_req_d     = mem_req;
        mem_addr_d    = mem_addr;
        instr_d       = instr;
        instr_valid_d = instr_valid;
        pc_advance_d  = 1'b0;
        fault_d       = fault;
        fault_code_d  = fault_code_q;
        unique case (state)
            IDLE: begin
                if (fetch_en && !aligned) begin
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_MISALIGN;
                end else if (fetch_en) begin
                    mem_addr_d = pc_in;
                    mem_req_d  = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                    mem_req_d     = 1'b0;
                end else if (expired) begin
                    mem_req_d    = 1'b0;
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            HOLD: begin
                if (instr_accept) begin
                    instr_valid_d = 1'b0;
                    pc_advance_d  = 1'b1;
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    fault_d      = 1'b0;
                    fault_code_d = FAULT_NONE;
                end
            end
            default: ;
        endcase
    end

endmodule
